wb_burst_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 32-bit wishbone-style output data port (wbOutputData / wbWriteOut path into zynq_bd) among NUM_REQ fabric requesters: SysGen result, serial-capture shim, IIC readback.
- Grants one requester at a time for a burst that ends on last-beat or on MAX_BURST beats, then rotates priority.
- Sits in top, between the requesters and the zynq_bd wb inputs.

---
 rtl/wb_arb_pkg.sv | 21 ++
 rtl/rr_pick.sv | 36 +++
 rtl/wb_burst_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_burst_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types and width helpers for the wishbone burst arbiter
package wb_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W = 32;

  // Width of a counter that must hold values 0..max_val inclusive
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  // Width of an index into n entries (at least one bit)
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority one-hot picker
module rr_pick #(
  parameter int N     = 4,
  parameter int PTR_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_rr_ptr,
  output logic [N-1:0]     o_pick,
  output logic             o_any_req
);

  int w_dist;
  int w_best_dist;
  int w_best_idx;

  assign o_any_req = |i_req;

  // Winner is the requester with the smallest forward distance from the pointer
  always_comb begin
    w_dist      = 0;
    w_best_dist = N;
    w_best_idx  = 0;
    o_pick      = '0;
    for (int i = 0; i < N; i++) begin
      w_dist = (i - int'(i_rr_ptr) + N) % N;
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best_idx  = i;
      end
    end
    for (int i = 0; i < N; i++) begin
      o_pick[i] = o_any_req && (i == w_best_idx);
    end
  end

endmodule

// File: rtl/wb_burst_arbiter.sv
// rtl/wb_burst_arbiter.sv - round-robin burst arbiter onto one wishbone data port (optional idle timeout: WB_ARB_TIMEOUT_EN)
module wb_burst_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      timeout_err
);

  localparam int CNT_W = cnt_width(MAX_BURST);
  localparam int PTR_W = ptr_width(NUM_REQ);

  arb_state_t         r_state, w_state_nxt;
  logic [NUM_REQ-1:0] r_grant, w_grant_nxt;
  logic [CNT_W-1:0]   r_beat_cnt, w_beat_cnt_nxt, w_beat_inc;
  logic [PTR_W-1:0]   r_rr_ptr, w_rr_ptr_nxt, w_next_ptr;
  logic [PTR_W-1:0]   w_gidx;
  logic [DATA_W-1:0]  w_out_data;
  logic [NUM_REQ-1:0] w_pick;
  logic               w_any_req;
  logic               w_gvalid;
  logic               w_glast;
  logic               w_xfer;
  logic               w_burst_done;
  logic               w_timeout_hit;

  rr_pick #(
    .N     (NUM_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req     (req_valid),
    .i_rr_ptr  (r_rr_ptr),
    .o_pick    (w_pick),
    .o_any_req (w_any_req)
  );

  // Owner index and data mux driven by the registered one-hot grant
  always_comb begin
    w_gidx     = '0;
    w_out_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_gidx     = PTR_W'(i);
        w_out_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_gvalid     = |(req_valid & r_grant);
  assign w_glast      = |(req_last & r_grant);
  assign out_data     = w_out_data;
  assign out_valid    = (r_state == XFER) && w_gvalid;
  assign req_ready    = ((r_state == XFER) && out_ready) ? r_grant : '0;
  assign grant        = r_grant;
  assign w_xfer       = out_valid && out_ready;
  assign w_beat_inc   = r_beat_cnt + CNT_W'(1);
  // last and MAX_BURST on the same beat collapse into one release
  assign w_burst_done = w_xfer && (w_glast || (w_beat_inc == CNT_W'(MAX_BURST)));
  assign w_next_ptr   = (w_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : (w_gidx + PTR_W'(1));

`ifdef WB_ARB_TIMEOUT_EN
  localparam int IDLE_W = cnt_width(TIMEOUT);

  logic [IDLE_W-1:0] r_idle_cnt, w_idle_cnt_nxt, w_idle_inc;
  logic              r_timeout_err;

  assign w_idle_inc    = r_idle_cnt + IDLE_W'(1);
  assign w_timeout_hit = (r_state == XFER) && !w_gvalid && (w_idle_inc == IDLE_W'(TIMEOUT));
  assign timeout_err   = r_timeout_err;

  // Count consecutive owner-idle cycles; any valid beat or release clears it
  always_comb begin
    w_idle_cnt_nxt = '0;
    if ((r_state == XFER) && !w_gvalid && !w_timeout_hit) begin
      w_idle_cnt_nxt = w_idle_inc;
    end
  end

  // Idle counter and one-cycle timeout pulse registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idle_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_idle_cnt    <= w_idle_cnt_nxt;
      r_timeout_err <= w_timeout_hit;
    end
  end
`else
  // Timeout disabled: a stalled owner keeps the grant until last or MAX_BURST
  assign w_timeout_hit = 1'b0;
  assign timeout_err   = 1'b0 & (TIMEOUT != 0);
`endif

  // Next state: pick in IDLE, count beats and release in XFER
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_beat_cnt_nxt = r_beat_cnt;
    w_rr_ptr_nxt   = r_rr_ptr;
    case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_state_nxt    = XFER;
          w_grant_nxt    = w_pick;
          w_beat_cnt_nxt = '0;
        end
      end
      XFER: begin
        if (w_burst_done || w_timeout_hit) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = '0;
          w_beat_cnt_nxt = '0;
          w_rr_ptr_nxt   = w_next_ptr;
        end else if (w_xfer) begin
          w_beat_cnt_nxt = w_beat_inc;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State, grant, beat counter and rotation pointer registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_beat_cnt <= '0;
      r_rr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_wb_burst_arbiter.sv
// tb/tb_wb_burst_arbiter.sv - self-checking bench for wb_burst_arbiter
module tb_wb_burst_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 32;
  localparam int MAXB = 8;
  localparam int TMO  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     req_last;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     out_data;
  logic              out_valid;
  logic              out_ready;
  logic [NR-1:0]     grant;
  logic              timeout_err;

  wb_burst_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .MAX_BURST (MAXB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  int n_tmo = 0;
  int cyc   = 0;

  int unsigned q_data[NR][$];
  bit          q_last[NR][$];
  bit          en[NR];

  typedef struct {
    int          cyc;
    logic [3:0]  g;
    logic [31:0] d;
  } ent_t;
  ent_t log_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Requesters present the head of their queue whenever enabled
  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      if (en[i] && q_data[i].size() > 0) begin
        req_valid[i]           = 1'b1;
        req_data[i*DW +: DW]   = q_data[i][0];
        req_last[i]            = q_last[i][0];
      end else begin
        req_valid[i]           = 1'b0;
        req_data[i*DW +: DW]   = '0;
        req_last[i]            = 1'b0;
      end
    end
  endtask

  task automatic push(input int r, input int n, input int unsigned base, input bit last_at_end);
    for (int k = 0; k < n; k++) begin
      q_data[r].push_back(base + k);
      q_last[r].push_back(last_at_end && (k == n - 1));
    end
  endtask

  task automatic clear_q();
    for (int i = 0; i < NR; i++) begin
      q_data[i].delete();
      q_last[i].delete();
      en[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_q();
    out_ready = 1'b1;
    drive();
    tick();
    tick();
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic chk_len(input int n);
    chk("log_len", 64'(log_q.size()), 64'(n));
  endtask

  task automatic chk_log(input int j, input int off, input logic [3:0] g, input int unsigned d);
    if (j >= log_q.size()) begin
      n_chk++;
      n_err++;
      $display("FAIL log_entry: entry %0d missing, only %0d beats seen", j, log_q.size());
    end else begin
      chk("log_offset", 64'(log_q[j].cyc - log_q[0].cyc), 64'(off));
      chk("log_grant", 64'(log_q[j].g), 64'(g));
      chk("log_data", 64'(log_q[j].d), 64'(d));
    end
  endtask

  // Transaction-level model: owner (-1 when idle), rotation pointer, beats, idle run
  int m_owner = -1;
  int m_ptr   = 0;
  int m_beats = 0;
  int m_idle  = 0;
  bit m_tmo   = 1'b0;
  int m_c;
  bit m_lastb;
  bit m_found;

  always @(posedge clk) cyc++;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      m_idle  = 0;
      m_tmo   = 1'b0;
    end else begin
      m_tmo = 1'b0;
      if (m_owner < 0) begin
        m_found = 1'b0;
        for (int k = 0; k < NR; k++) begin
          m_c = (m_ptr + k) % NR;
          if (!m_found && req_valid[m_c]) begin
            m_owner = m_c;
            m_found = 1'b1;
          end
        end
        m_beats = 0;
        m_idle  = 0;
      end else if (req_valid[m_owner] && out_ready) begin
        m_beats++;
        m_idle  = 0;
        m_lastb = req_last[m_owner];
        void'(q_data[m_owner].pop_front());
        void'(q_last[m_owner].pop_front());
        if (m_lastb || m_beats == MAXB) begin
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
          m_beats = 0;
        end
      end else if (req_valid[m_owner]) begin
        m_idle = 0;
      end else begin
`ifdef WB_ARB_TIMEOUT_EN
        m_idle++;
        if (m_idle == TMO) begin
          m_ptr   = (m_owner + 1) % NR;
          m_owner = -1;
          m_beats = 0;
          m_idle  = 0;
          m_tmo   = 1'b1;
        end
`endif
      end
    end
  end

  logic [NR-1:0] e_grant;
  logic [NR-1:0] e_ready;
  logic          e_valid;

  // Compare DUT against the model mid-cycle, and log accepted beats
  always @(negedge clk) begin
    if (!rst) begin
      e_grant = (m_owner >= 0) ? NR'(1 << m_owner) : '0;
      e_ready = (m_owner >= 0 && out_ready) ? e_grant : '0;
      e_valid = (m_owner >= 0) ? req_valid[m_owner] : 1'b0;
      chk("grant", 64'(grant), 64'(e_grant));
      chk("req_ready", 64'(req_ready), 64'(e_ready));
      chk("out_valid", 64'(out_valid), 64'(e_valid));
      chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
      if (e_valid) chk("out_data", 64'(out_data), 64'(req_data[m_owner*DW +: DW]));
      if (out_valid && out_ready) log_q.push_back('{cyc, grant, out_data});
      if (timeout_err) n_tmo++;
    end
  end

  initial begin
    rst       = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    clear_q();
    #2 rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("rst_grant", 64'(grant), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_data", 64'(out_data), 64'h0);
    chk("rst_timeout_err", 64'(timeout_err), 64'h0);

    // Two 3-beat bursts from req0 and req2 with a one-cycle gap
    push(0, 3, 32'hA0, 1'b1);
    push(2, 3, 32'hC0, 1'b1);
    drive();
    run(12);
    chk_len(6);
    chk_log(0, 0, 4'b0001, 32'hA0);
    chk_log(1, 1, 4'b0001, 32'hA1);
    chk_log(2, 2, 4'b0001, 32'hA2);
    chk_log(3, 4, 4'b0100, 32'hC0);
    chk_log(4, 5, 4'b0100, 32'hC1);
    chk_log(5, 6, 4'b0100, 32'hC2);

    // Pointer now at 3: req3 beats req0
    log_q.delete();
    push(0, 1, 32'hB0, 1'b1);
    push(3, 1, 32'h30, 1'b1);
    drive();
    run(8);
    chk_len(2);
    chk_log(0, 0, 4'b1000, 32'h30);
    chk_log(1, 2, 4'b0001, 32'hB0);

    // All four continuously valid, no last: 8 beats each, order 0,1,2,3,0
    do_reset();
    for (int r = 0; r < NR; r++) push(r, 40, 32'(r * 256), 1'b0);
    drive();
    run(50);
    for (int j = 0; j < 40; j++) begin
      chk_log(j, j + j / 8, 4'(1 << ((j / 8) % 4)),
              32'(((j / 8) % 4) * 256 + (j / 32) * 8 + (j % 8)));
    end

    // out_ready alternating during a 4-beat req1 burst
    do_reset();
    push(1, 4, 32'h10, 1'b1);
    drive();
    tick();
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 2 == 0);
      tick();
    end
    out_ready = 1'b1;
    drive();
    run(3);
    chk_len(4);
    chk_log(0, 0, 4'b0010, 32'h10);
    chk_log(1, 2, 4'b0010, 32'h11);
    chk_log(2, 4, 4'b0010, 32'h12);
    chk_log(3, 6, 4'b0010, 32'h13);

    // Reset on beat 2 of a 5-beat req3 burst, then restart from beat 0
    do_reset();
    push(3, 5, 32'h50, 1'b1);
    drive();
    tick();
    tick();
    tick();
    #1 rst = 1'b1;
    log_q.delete();
    #1;
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_req_ready", 64'(req_ready), 64'h0);
    tick();
    rst = 1'b0;
    clear_q();
    push(3, 5, 32'h50, 1'b1);
    drive();
    run(10);
    chk_len(5);
    chk_log(0, 0, 4'b1000, 32'h50);
    chk_log(4, 4, 4'b1000, 32'h54);

    // req2 sends one beat then stalls with req3 waiting
    do_reset();
    n_tmo = 0;
    push(2, 1, 32'h20, 1'b0);
    push(3, 1, 32'h33, 1'b1);
    drive();
`ifdef WB_ARB_TIMEOUT_EN
    run(30);
    chk_len(2);
    chk_log(0, 0, 4'b0100, 32'h20);
    chk_log(1, 18, 4'b1000, 32'h33);
    chk("timeout_pulses", 64'(n_tmo), 64'd1);
`else
    run(120);
    chk_len(1);
    chk_log(0, 0, 4'b0100, 32'h20);
    chk("held_grant", 64'(grant), 64'h4);
    chk("timeout_pulses", 64'(n_tmo), 64'd0);
`endif

    // last coincides with MAX_BURST on beat 8 of req0, req1 waiting
    do_reset();
    push(0, 8, 32'h60, 1'b1);
    push(1, 1, 32'h71, 1'b1);
    drive();
    run(14);
    chk_len(9);
    chk_log(7, 7, 4'b0001, 32'h67);
    chk_log(8, 9, 4'b0010, 32'h71);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
